stupidrv_mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the stupidrv instruction-fetch and data ports. It sits between the stupidrv core and the RAM and also decodes the output MMIO word.
- Data accesses take priority over fetch. The core is stalled one cycle per RAM data access while the pending fetch is replayed.
- Writes to the output address go to a registered output port and never touch RAM or stall.
- Out-of-range accesses are flagged and dropped.

---
 rtl/stupidrv_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_stupidrv_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stupidrv_mem_arbiter.sv
// stupidrv_mem_arbiter: lets the stupidrv fetch and data ports share one
// single-port synchronous RAM, and decodes the output MMIO word.
// A RAM data access takes the RAM for one cycle and stalls the core. The
// fetch that was displaced is replayed in the following cycle.
// Optional build macro: STUPIDRV_ARB_PERF_EN adds the stall and data-access
// performance counters.
module stupidrv_mem_arbiter #(
    parameter int          MEM_ADDR_WIDTH = 10,
    parameter logic [31:0] OUT_ADDR       = 32'h02000000
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [31:0]               imem_addr,
    output logic [31:0]               imem_data,
    input  logic                      dmem_valid,
    input  logic [31:0]               dmem_addr,
    input  logic [3:0]                dmem_wstrb,
    input  logic [31:0]               dmem_wdata,
    output logic [31:0]               dmem_rdata,
    output logic                      stall,
    output logic                      mem_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]                mem_wstrb,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic                      out_valid,
    output logic [31:0]               out_data,
`ifdef STUPIDRV_ARB_PERF_EN
    output logic [31:0]               perf_stalls,
    output logic [31:0]               perf_daccess,
`endif
    output logic                      err_addr
);

    typedef enum logic [0:0] {S_RUN, S_DATA} state_t;

    localparam logic [29:0] MEM_WORDS = 30'(1) << MEM_ADDR_WIDTH;

    state_t      state_reg, state_next;
    logic [31:0] fetch_q_reg;
    logic        data_wr_reg;
    logic        fetch_pend_reg;
    logic [31:0] imem_hold_reg;
    logic [31:0] dmem_rdata_reg;
    logic        out_valid_reg;
    logic [31:0] out_data_reg;
    logic        err_reg;

    logic        mem_hit, out_hit;
    logic        fetch_issue, fetch_ok, data_issue, out_issue, err_issue;
    logic [31:0] fetch_addr;
    logic [31:0] out_merge;
    logic        unused_addr_bits;

    assign mem_hit          = dmem_addr[31:2] < MEM_WORDS;
    assign out_hit          = dmem_addr == OUT_ADDR;
    assign unused_addr_bits = ^fetch_addr[1:0];

    // Byte-merge of the output write: strobed bytes pass, the rest read 0.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out_merge
            assign out_merge[gi*8 +: 8] = dmem_wstrb[gi] ? dmem_wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Next-state and RAM port steering; everything is idle while in reset.
    always_comb begin
        state_next  = state_reg;
        stall       = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;
        mem_wstrb   = 4'h0;
        fetch_issue = 1'b0;
        fetch_addr  = imem_addr;
        fetch_ok    = 1'b0;
        data_issue  = 1'b0;
        out_issue   = 1'b0;
        err_issue   = 1'b0;
        if (resetn) begin
            case (state_reg)
                S_RUN: begin
                    if (dmem_valid && mem_hit) begin
                        mem_en     = 1'b1;
                        mem_addr   = dmem_addr[MEM_ADDR_WIDTH+1:2];
                        mem_wstrb  = dmem_wstrb;
                        stall      = 1'b1;
                        data_issue = 1'b1;
                        state_next = S_DATA;
                    end else begin
                        fetch_issue = 1'b1;
                        fetch_addr  = imem_addr;
                        if (dmem_valid && out_hit) begin
                            out_issue = 1'b1;
                        end else if (dmem_valid) begin
                            err_issue = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    // The held request is not re-issued; replay the fetch.
                    fetch_issue = 1'b1;
                    fetch_addr  = fetch_q_reg;
                    state_next  = S_RUN;
                end
                default: state_next = S_RUN;
            endcase
            if (fetch_issue) begin
                fetch_ok = fetch_addr[31:2] < MEM_WORDS;
                mem_addr = fetch_addr[MEM_ADDR_WIDTH+1:2];
                mem_en   = fetch_ok;
            end
        end
    end

    assign mem_wdata = dmem_wdata;

    // State, displaced-fetch capture and fetch-return tracking.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_RUN;
            fetch_q_reg    <= 32'h0;
            data_wr_reg    <= 1'b0;
            fetch_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_pend_reg <= fetch_issue && fetch_ok;
            if (data_issue) begin
                fetch_q_reg <= imem_addr;
                data_wr_reg <= |dmem_wstrb;
            end
        end
    end

    // Holds the last fetched word so imem_data stays stable across a stall;
    // a rejected fetch reads as 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            imem_hold_reg <= 32'h0;
        end else if (fetch_issue && !fetch_ok) begin
            imem_hold_reg <= 32'h0;
        end else if (fetch_pend_reg) begin
            imem_hold_reg <= mem_rdata;
        end
    end

    assign imem_data = fetch_pend_reg ? mem_rdata : imem_hold_reg;

    // Data read result: RAM word on a read, 0 for writes, MMIO and bad addresses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dmem_rdata_reg <= 32'h0;
        end else if (state_reg == S_DATA) begin
            dmem_rdata_reg <= data_wr_reg ? 32'h0 : mem_rdata;
        end else if (out_issue || err_issue) begin
            dmem_rdata_reg <= 32'h0;
        end
    end

    // Output MMIO word and the sticky address-error flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 32'h0;
            err_reg       <= 1'b0;
        end else begin
            out_valid_reg <= out_issue && (|dmem_wstrb);
            if (out_issue && (|dmem_wstrb)) begin
                out_data_reg <= out_merge;
            end
            if (err_issue || (fetch_issue && !fetch_ok)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign dmem_rdata = dmem_rdata_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign err_addr   = err_reg;

`ifdef STUPIDRV_ARB_PERF_EN
    logic [31:0] perf_stalls_reg, perf_daccess_reg;

    // Saturating counters of stall cycles and RAM data accesses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_stalls_reg  <= 32'h0;
            perf_daccess_reg <= 32'h0;
        end else begin
            if (stall && perf_stalls_reg != 32'hFFFFFFFF) begin
                perf_stalls_reg <= perf_stalls_reg + 32'd1;
            end
            if (data_issue && perf_daccess_reg != 32'hFFFFFFFF) begin
                perf_daccess_reg <= perf_daccess_reg + 32'd1;
            end
        end
    end

    assign perf_stalls  = perf_stalls_reg;
    assign perf_daccess = perf_daccess_reg;
`endif

endmodule

// File: tb/tb_stupidrv_mem_arbiter.sv
// Directed bench for stupidrv_mem_arbiter with a behavioural single-port RAM.
module tb_stupidrv_mem_arbiter;

    localparam int MAW = 10;

    logic           clock = 1'b0;
    logic           resetn;
    logic [31:0]    imem_addr;
    logic [31:0]    imem_data;
    logic           dmem_valid;
    logic [31:0]    dmem_addr;
    logic [3:0]     dmem_wstrb;
    logic [31:0]    dmem_wdata;
    logic [31:0]    dmem_rdata;
    logic           stall;
    logic           mem_en;
    logic [MAW-1:0] mem_addr;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata = 32'h0;
    logic           out_valid;
    logic [31:0]    out_data;
    logic           err_addr;
`ifdef STUPIDRV_ARB_PERF_EN
    logic [31:0]    perf_stalls;
    logic [31:0]    perf_daccess;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [0:(1<<MAW)-1];

    always #5 clock = ~clock;

    stupidrv_mem_arbiter #(.MEM_ADDR_WIDTH(MAW), .OUT_ADDR(32'h02000000)) dut (
        .clock(clock), .resetn(resetn),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .stall(stall), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data),
`ifdef STUPIDRV_ARB_PERF_EN
        .perf_stalls(perf_stalls), .perf_daccess(perf_daccess),
`endif
        .err_addr(err_addr)
    );

    // Single-port synchronous RAM with byte write enables and registered read.
    always @(posedge clock) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic data_req(input logic v, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        dmem_valid = v;
        dmem_addr  = a;
        dmem_wstrb = s;
        dmem_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1<<MAW); i++) ram[i] = 32'h0;
        ram[0]  = 32'h11;
        ram[1]  = 32'h22;
        ram[2]  = 32'h33;
        ram[3]  = 32'h44;
        ram[4]  = 32'h55;
        ram[64] = 32'hCAFEBABE;
        ram[65] = 32'h12345678;

        resetn    = 1'b0;
        imem_addr = 32'h0;
        data_req(1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) tick();
        settle();
        check("rst_stall", stall, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_imem_data", imem_data, 0);
        check("rst_dmem_rdata", dmem_rdata, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_addr, 0);

        // Plain fetch stream
        tick(); resetn = 1'b1; imem_addr = 32'h0; settle();
        check("f0_mem_en", mem_en, 1);
        check("f0_mem_addr", mem_addr, 0);
        tick(); imem_addr = 32'h4; settle();
        check("f0_imem_data", imem_data, 32'h11);
        check("f0_stall", stall, 0);

        // Data read at 0x100 with fetch 0x8 displaced
        tick(); imem_addr = 32'h8; data_req(1'b1, 32'h100, 4'h0, 32'h0); settle();
        check("f1_imem_data", imem_data, 32'h22);
        check("rd_stall", stall, 1);
        check("rd_mem_addr", mem_addr, 64);
        tick(); settle();
        check("rd_replay_stall", stall, 0);
        check("rd_replay_addr", mem_addr, 2);
        check("rd_hold_imem", imem_data, 32'h22);
        tick(); imem_addr = 32'hC; data_req(1'b0, 32'h0, 4'h0, 32'h0); settle();
        check("rd_dmem_rdata", dmem_rdata, 32'hCAFEBABE);
        check("rd_imem_data", imem_data, 32'h33);
        check("rd_next_addr", mem_addr, 3);

        // Partial write at 0x104
        tick(); imem_addr = 32'h10; data_req(1'b1, 32'h104, 4'b0011, 32'hAABBCCDD); settle();
        check("wr_stall", stall, 1);
        check("wr_mem_wstrb", mem_wstrb, 4'b0011);
        check("wr_mem_addr", mem_addr, 65);
        check("wr_imem_data", imem_data, 32'h44);
        tick(); settle();
        check("wr_replay_stall", stall, 0);
        check("wr_replay_wstrb", mem_wstrb, 0);
        check("wr_replay_addr", mem_addr, 4);
        tick(); imem_addr = 32'h14; data_req(1'b0, 32'h0, 4'h0, 32'h0); settle();
        check("wr_dmem_rdata", dmem_rdata, 0);
        check("wr_imem_data", imem_data, 32'h55);
        check("wr_ram65", ram[65], 32'h1234CCDD);

        // Output MMIO writes
        tick(); imem_addr = 32'h18; data_req(1'b1, 32'h02000000, 4'hF, 32'd42); settle();
        check("out_stall", stall, 0);
        check("out_fetch_addr", mem_addr, 6);
        check("out_mem_wstrb", mem_wstrb, 0);
        check("out_valid_pre", out_valid, 0);
        tick(); imem_addr = 32'h1C; data_req(1'b0, 32'h0, 4'h0, 32'h0); settle();
        check("out_valid", out_valid, 1);
        check("out_data", out_data, 32'd42);
        tick(); imem_addr = 32'h20; data_req(1'b1, 32'h02000000, 4'b0100, 32'h11223344); settle();
        check("out_valid_gap", out_valid, 0);
        tick(); imem_addr = 32'h24; data_req(1'b0, 32'h0, 4'h0, 32'h0); settle();
        check("out_valid_b2", out_valid, 1);
        check("out_data_b2", out_data, 32'h00220000);
        check("out_ram64", ram[64], 32'hCAFEBABE);

        // Out-of-range data read
        tick(); imem_addr = 32'h0; data_req(1'b1, 32'h8000, 4'h0, 32'h0); settle();
        check("err_stall", stall, 0);
        check("err_pre", err_addr, 0);
        tick(); data_req(1'b0, 32'h0, 4'h0, 32'h0); settle();
        check("err_set", err_addr, 1);
        check("err_rdata", dmem_rdata, 0);
        tick(); tick(); settle();
        check("err_sticky", err_addr, 1);

        // Out-of-range fetch
        tick(); imem_addr = 32'h1000; settle();
        check("bad_fetch_en", mem_en, 0);
        tick(); imem_addr = 32'h0; settle();
        check("bad_fetch_data", imem_data, 0);
        tick(); imem_addr = 32'h4; settle();
        check("after_bad_data", imem_data, 32'h11);

        // Reset while in S_DATA
        tick(); imem_addr = 32'h4; data_req(1'b1, 32'h100, 4'h0, 32'h0); settle();
        check("rs_stall_pre", stall, 1);
        tick(); resetn = 1'b0; settle();
        check("rs_stall", stall, 0);
        check("rs_mem_en", mem_en, 0);
        check("rs_err_clr", err_addr, 0);
        check("rs_imem_data", imem_data, 0);
        tick(); resetn = 1'b1; imem_addr = 32'h8; data_req(1'b0, 32'h0, 4'h0, 32'h0); settle();
        check("rs_resume_en", mem_en, 1);
        check("rs_resume_addr", mem_addr, 2);
        check("rs_resume_stall", stall, 0);
        tick(); imem_addr = 32'hC; settle();
        check("rs_resume_data", imem_data, 32'h33);
        check("rs_dmem_rdata", dmem_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
